axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI3/AXI4 memory responder (subordinate), the far end of the master interface driven by the axis stream engines.
- Accepts INCR write bursts (AW/W/B) and read bursts (AR/R) and services them from an internal dual-port RAM.
- Serves as the DDR/HP-port stand-in for simulation, and as an on-chip scratch memory behind the stream engines.
- Write and read paths are independent and run concurrently.

Parameters:
- AXI_ID_WIDTH, 8, width of all ID fields.
- AXI_LEN_WIDTH, 8, width of awlen/arlen.
- AXI_ADDR_WIDTH, 32, byte address width.
- AXI_DATA_WIDTH, 256, data bus width; power of two, minimum 8.
- MEM_AWIDTH, 10, log2 of RAM depth in AXI_DATA_WIDTH words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- axi_awid  in  AXI_ID_WIDTH  write burst ID
- axi_awaddr  in  AXI_ADDR_WIDTH  write start byte address
- axi_awlen  in  AXI_LEN_WIDTH  beats minus one
- axi_awvalid  in  1  AW valid
- axi_awready  out  1  AW ready
- axi_wdata  in  AXI_DATA_WIDTH  write data
- axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables
- axi_wlast  in  1  last write beat
- axi_wvalid  in  1  W valid
- axi_wready  out  1  W ready
- axi_bid  out  AXI_ID_WIDTH  response ID
- axi_bresp  out  2  write response
- axi_bvalid  out  1  B valid
- axi_bready  in  1  B ready
- axi_arid  in  AXI_ID_WIDTH  read burst ID
- axi_araddr  in  AXI_ADDR_WIDTH  read start byte address
- axi_arlen  in  AXI_LEN_WIDTH  beats minus one
- axi_arvalid  in  1  AR valid
- axi_arready  out  1  AR ready
- axi_rid  out  AXI_ID_WIDTH  read ID
- axi_rdata  out  AXI_DATA_WIDTH  read data
- axi_rresp  out  2  read response
- axi_rlast  out  1  last read beat
- axi_rvalid  out  1  R valid
- axi_rready  in  1  R ready

Behaviour:
- Reset: all FSMs go to IDLE and all valid/ready outputs are 0. A flag `live` is cleared by reset and set on the first clk edge after release. awready and arready are gated by `live`. RAM contents are not reset.
- Addressing: LSB = log2(AXI_DATA_WIDTH/8). Word index = addr[LSB+MEM_AWIDTH-1:LSB]; low bits below LSB are ignored. The word index increments by 1 per beat and wraps modulo 2^MEM_AWIDTH. Size and burst fields are not ports; full-width INCR only.
- Write FSM:
  - W_IDLE: awready = live. On AW handshake, capture awid, word index and awlen into a beat counter, then go to W_DATA.
  - W_DATA: wready = 1. Each W handshake writes wdata under wstrb at the current index, then increments the index and counter.
    - An error flag is set if wlast = 1 on a beat other than awlen, or wlast = 0 on beat awlen.
    - The burst ends on beat awlen regardless of wlast; go to W_RESP.
    - After an early wlast, the remaining beats are still accepted.
  - W_RESP: bvalid = 1, bid = captured ID, bresp = SLVERR (2'b10) if the error flag is set, otherwise OKAY (2'b00). Hold until bready, then go to W_IDLE.
  - Latency: AW handshake at cycle N gives wready at N+1. Last W handshake at M gives bvalid at M+1.
- Read FSM (RAM read port has an enable; its output register holds when en = 0):
  - R_IDLE: arready = live. On AR handshake, issue a RAM read at the araddr index, capture arid/arlen, go to R_DATA.
  - R_DATA: rvalid = 1, rdata = RAM output, rid = captured ID, rresp = OKAY, rlast = (beat counter == arlen).
    - On an R handshake with rlast = 0: read the next index the same cycle, so beats are back-to-back.
    - On an R handshake with rlast = 1: go to R_IDLE.
    - While rready = 0: rdata and all R outputs are held stable.
  - Latency: AR handshake at N gives first rvalid at N+1. With rready held high, throughput is one beat per cycle.
  - A new AR is not accepted until the cycle after the rlast handshake.
- Collision: a write and a read to the same word in the same cycle return the old data (read-first).
- awlen = 0 and arlen = 0 are single beats. Maximum length is 2^AXI_LEN_WIDTH beats.
- Reset asserted mid-burst: FSMs abort to IDLE immediately and no B or R completes. RAM keeps the beats already written.

Decomposition:
- Package axi_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, BURST_INCR = 2'b01.
  - A function clog2 for LSB.
- One sub-module, axi_mem_ram: simple dual-port RAM with 1 write port (per-byte enables) and 1 read port (enable, registered output), read-first, depth 2^MEM_AWIDTH.

Test Plan:
- Single beat: AW addr 0x40, len 0, wdata 0xA5.., strb all 1 → bvalid next cycle after W, bresp 00. Then AR 0x40, len 0 → rdata 0xA5.., rlast = 1, rvalid at AR+1.
- Burst: 16-beat write at 0x0 with data = beat index, then 16-beat read with rready = 1 → 16 consecutive rvalid cycles, data 0..15, rlast only on beat 15.
- Backpressure: during the 16-beat read, toggle rready randomly → rdata stable while stalled, sequence still 0..15, no beats lost or repeated.
- Strobes and errors:
  - Write 0xFF.. then write 0x00.. with strb = 0x0000000F → readback has the low 4 bytes 0x00 and the rest 0xFF.
  - A 4-beat write with wlast on beat 1 → bresp = 10.
- Wrap and concurrency: with MEM_AWIDTH = 4, write 4 beats starting at word 14 → words 14, 15, 0, 1. Run a concurrent read of word 0 in the same cycle as its write → old value returned.
- Reset: assert rst low in the middle of a read burst → rvalid = 0 immediately. arready = 0 until one cycle after release, then 1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and elaboration-time helpers for the memory responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, enabled read port with a registered output.
// A read and a write to the same word in one cycle return the old contents.
module axi_mem_ram #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Both updates are non-blocking, so a same-address read sees the pre-write value.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem[raddr_i];
        if (we_i) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wstrb_i[i]) mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI memory responder: independent INCR write (AW/W/B) and read (AR/R) engines
// servicing bursts from an internal dual-port RAM.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_LEN_WIDTH  = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned MEM_AWIDTH     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_awlen,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_wlast,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]    axi_arlen,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready
);

    localparam int unsigned LSB = clog2(AXI_DATA_WIDTH / 8);

    typedef logic [MEM_AWIDTH-1:0] idx_t;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    logic live_q;

    w_state_e                 w_state_q;
    idx_t                     w_idx_q;
    logic [AXI_LEN_WIDTH-1:0] w_cnt_q, w_len_q;
    logic [AXI_ID_WIDTH-1:0]  w_id_q;
    logic                     w_err_q;

    r_state_e                 r_state_q;
    idx_t                     r_idx_q;
    logic [AXI_LEN_WIDTH-1:0] r_cnt_q, r_len_q;
    logic [AXI_ID_WIDTH-1:0]  r_id_q;

    logic aw_hs, w_hs, w_last_beat, ar_hs, r_hs, r_last_beat, ram_re;
    idx_t aw_idx, ar_idx, ram_raddr;
    logic unused_addr;

    // Only the word-index bits of the addresses matter.
    assign unused_addr = ^{axi_awaddr, axi_araddr};
    assign aw_idx      = axi_awaddr[LSB +: MEM_AWIDTH];
    assign ar_idx      = axi_araddr[LSB +: MEM_AWIDTH];

    // Holds address acceptance off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live_q <= 1'b0;
        else      live_q <= 1'b1;
    end

    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign w_last_beat = (w_cnt_q == w_len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= WIdle;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: if (aw_hs) begin
                    w_id_q    <= axi_awid;
                    w_idx_q   <= aw_idx;
                    w_len_q   <= axi_awlen;
                    w_cnt_q   <= '0;
                    w_err_q   <= 1'b0;
                    w_state_q <= WData;
                end
                // The burst length comes from awlen; wlast only feeds the error flag.
                WData: if (w_hs) begin
                    w_idx_q <= w_idx_q + 1'b1;
                    w_cnt_q <= w_cnt_q + 1'b1;
                    w_err_q <= w_err_q | (axi_wlast != w_last_beat);
                    if (w_last_beat) w_state_q <= WResp;
                end
                WResp: if (axi_bready) w_state_q <= WIdle;
                default: w_state_q <= WIdle;
            endcase
        end
    end

    assign axi_awready = live_q && (w_state_q == WIdle);
    assign axi_wready  = (w_state_q == WData);
    assign axi_bvalid  = (w_state_q == WResp);
    assign axi_bid     = w_id_q;
    assign axi_bresp   = w_err_q ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_hs        = axi_rvalid && axi_rready;
    assign r_last_beat = (r_cnt_q == r_len_q);

    // Prefetch the next word on every accepted non-last beat; a stall leaves the RAM output held.
    assign ram_re    = ar_hs || (r_hs && !r_last_beat);
    assign ram_raddr = (r_state_q == RIdle) ? ar_idx : r_idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= RIdle;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_id_q    <= '0;
        end else begin
            unique case (r_state_q)
                RIdle: if (ar_hs) begin
                    r_id_q    <= axi_arid;
                    r_len_q   <= axi_arlen;
                    r_cnt_q   <= '0;
                    r_idx_q   <= ar_idx + 1'b1;
                    r_state_q <= RData;
                end
                RData: if (r_hs) begin
                    if (r_last_beat) begin
                        r_state_q <= RIdle;
                    end else begin
                        r_idx_q <= r_idx_q + 1'b1;
                        r_cnt_q <= r_cnt_q + 1'b1;
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    assign axi_arready = live_q && (r_state_q == RIdle);
    assign axi_rvalid  = (r_state_q == RData);
    assign axi_rid     = r_id_q;
    assign axi_rresp   = RESP_OKAY;
    assign axi_rlast   = (r_state_q == RData) && r_last_beat;

    axi_mem_ram #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .ADDR_WIDTH (MEM_AWIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (w_hs),
        .waddr_i (w_idx_q),
        .wdata_i (axi_wdata),
        .wstrb_i (axi_wstrb),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (axi_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder against a word-array memory model.
module tb_axi_mem_responder;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    axi_awid = '0;
    logic [31:0]   axi_awaddr = '0;
    logic [7:0]    axi_awlen = '0;
    logic          axi_awvalid = 1'b0;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata = '0;
    logic [SW-1:0] axi_wstrb = '0;
    logic          axi_wlast = 1'b0;
    logic          axi_wvalid = 1'b0;
    logic          axi_wready;
    logic [7:0]    axi_bid;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready = 1'b0;
    logic [7:0]    axi_arid = '0;
    logic [31:0]   axi_araddr = '0;
    logic [7:0]    axi_arlen = '0;
    logic          axi_arvalid = 1'b0;
    logic          axi_arready;
    logic [7:0]    axi_rid;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wdata_buf [256];
    logic [SW-1:0] wstrb_buf [256];
    logic [DW-1:0] rdata_buf [256];
    logic          rlast_buf [256];
    logic [7:0]    rid_buf   [256];

    axi_mem_responder #(
        .AXI_ID_WIDTH   (8),
        .AXI_LEN_WIDTH  (8),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (DW),
        .MEM_AWIDTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 5) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_write(input int start, input int len);
        for (int b = 0; b <= len; b++) begin
            for (int k = 0; k < SW; k++) begin
                if (wstrb_buf[b][k])
                    model_mem[(start + b) % DEPTH][k*8 +: 8] = wdata_buf[b][k*8 +: 8];
            end
        end
    endtask

    // Drives one write burst from wdata_buf/wstrb_buf; early_last < 0 means wlast on the final beat.
    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int early_last, input bit gaps, output logic [1:0] bresp,
                            output logic [7:0] bid, output bit lat_ok, output bit timeout);
        int budget;
        lat_ok = 1;
        timeout = 0;
        bresp = 'x;
        bid = 'x;
        axi_awid = id;
        axi_awaddr = addr;
        axi_awlen = len[7:0];
        axi_awvalid = 1'b1;
        budget = 0;
        while (axi_awready !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        if (axi_awready !== 1'b1) begin
            axi_awvalid = 1'b0;
            timeout = 1;
            return;
        end
        tick();
        axi_awvalid = 1'b0;
        if (axi_wready !== 1'b1) lat_ok = 0;
        for (int b = 0; b <= len; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                axi_wvalid = 1'b0;
                tick();
            end
            axi_wdata = wdata_buf[b];
            axi_wstrb = wstrb_buf[b];
            axi_wlast = (early_last >= 0) ? (b == early_last) : (b == len);
            axi_wvalid = 1'b1;
            budget = 0;
            while (axi_wready !== 1'b1 && budget < 100) begin
                tick();
                budget++;
            end
            if (axi_wready !== 1'b1) begin
                axi_wvalid = 1'b0;
                timeout = 1;
                return;
            end
            tick();
        end
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
        if (axi_bvalid !== 1'b1) lat_ok = 0;
        bresp = axi_bresp;
        bid = axi_bid;
        repeat ($urandom_range(0, 2)) begin
            tick();
            if (axi_bvalid !== 1'b1) lat_ok = 0;
        end
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        if (axi_bvalid !== 1'b0) lat_ok = 0;
        model_write(word_of(addr), len);
    endtask

    // Reads one burst into rdata_buf/rlast_buf/rid_buf; bp randomises rready.
    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input bit bp, output bit lat_ok, output bit stable_ok,
                           output bit timeout);
        int budget, b;
        logic [DW-1:0] held_d;
        logic held_l;
        lat_ok = 1;
        stable_ok = 1;
        timeout = 0;
        axi_arid = id;
        axi_araddr = addr;
        axi_arlen = len[7:0];
        axi_arvalid = 1'b1;
        budget = 0;
        while (axi_arready !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        if (axi_arready !== 1'b1) begin
            axi_arvalid = 1'b0;
            timeout = 1;
            return;
        end
        tick();
        axi_arvalid = 1'b0;
        if (axi_rvalid !== 1'b1) lat_ok = 0;
        b = 0;
        budget = 0;
        while (b <= len && budget < 3000) begin
            axi_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_rvalid !== 1'b1) begin
                lat_ok = 0;
                tick();
            end else if (axi_rready) begin
                rdata_buf[b] = axi_rdata;
                rlast_buf[b] = axi_rlast;
                rid_buf[b] = axi_rid;
                b++;
                tick();
            end else begin
                held_d = axi_rdata;
                held_l = axi_rlast;
                tick();
                if (axi_rvalid !== 1'b1 || axi_rdata !== held_d || axi_rlast !== held_l)
                    stable_ok = 0;
            end
            budget++;
        end
        axi_rready = 1'b0;
        if (b <= len) timeout = 1;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) lat_ok = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        n_checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (axi_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_arready_before_live: got %b expected 0", axi_arready);
        end
        tick();
        n_checks++;
        if (axi_arready !== 1'b1 || axi_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_live: got %b%b expected 11", axi_awready, axi_arready);
        end
    endtask

    task automatic test_single;
        logic [1:0] bresp;
        logic [7:0] bid;
        logic [DW-1:0] expv;
        bit lat_ok, stable_ok, timeout;
        expv = {SW{8'hA5}};
        wdata_buf[0] = expv;
        wstrb_buf[0] = '1;
        do_write(8'h3C, 32'h40, 0, -1, 0, bresp, bid, lat_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || bresp !== 2'b00 || bid !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_write: got to=%0d lat=%0d bresp=%b bid=%h expected 0 1 00 3c",
                     timeout, lat_ok, bresp, bid);
        end
        do_read(8'h5A, 32'h40, 0, 0, lat_ok, stable_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || rdata_buf[0] !== expv || rlast_buf[0] !== 1'b1
            || rid_buf[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_read: got to=%0d lat=%0d data=%h last=%b rid=%h expected %h 1 5a",
                     timeout, lat_ok, rdata_buf[0], rlast_buf[0], rid_buf[0], expv);
        end
    endtask

    task automatic test_burst;
        logic [1:0] bresp;
        logic [7:0] bid;
        bit lat_ok, stable_ok, timeout;
        for (int b = 0; b < 16; b++) begin
            wdata_buf[b] = DW'(b);
            wstrb_buf[b] = '1;
        end
        do_write(8'h11, 32'h0, 15, -1, 1, bresp, bid, lat_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || bresp !== 2'b00 || bid !== 8'h11) begin
            n_fail++;
            $display("FAIL burst_write: got to=%0d lat=%0d bresp=%b bid=%h expected 0 1 00 11",
                     timeout, lat_ok, bresp, bid);
        end
        do_read(8'h22, 32'h0, 15, 0, lat_ok, stable_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok) begin
            n_fail++;
            $display("FAIL burst_read_throughput: got to=%0d lat=%0d expected 0 1", timeout, lat_ok);
        end
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (rdata_buf[b] !== DW'(b) || rlast_buf[b] !== (b == 15)) begin
                n_fail++;
                $display("FAIL burst_beat%0d: got data=%h last=%b expected %0d last=%0d",
                         b, rdata_buf[b], rlast_buf[b], b, b == 15);
            end
        end
    endtask

    task automatic test_backpressure;
        bit lat_ok, stable_ok, timeout;
        do_read(8'h33, 32'h0, 15, 1, lat_ok, stable_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || !stable_ok) begin
            n_fail++;
            $display("FAIL bp_protocol: got to=%0d lat=%0d stable=%0d expected 0 1 1",
                     timeout, lat_ok, stable_ok);
        end
        for (int b = 0; b < 16; b++) begin
            n_checks++;
            if (rdata_buf[b] !== DW'(b) || rlast_buf[b] !== (b == 15) || rid_buf[b] !== 8'h33) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got data=%h last=%b rid=%h expected %0d last=%0d 33",
                         b, rdata_buf[b], rlast_buf[b], rid_buf[b], b, b == 15);
            end
        end
    endtask

    task automatic test_strobe;
        logic [1:0] bresp;
        logic [7:0] bid;
        logic [DW-1:0] expv;
        bit lat_ok, stable_ok, timeout;
        expv = {{(SW - 4){8'hFF}}, 32'h0};
        wdata_buf[0] = '1;
        wstrb_buf[0] = '1;
        do_write(8'h01, 32'hA0, 0, -1, 0, bresp, bid, lat_ok, timeout);
        wdata_buf[0] = '0;
        wstrb_buf[0] = 32'h0000_000F;
        do_write(8'h02, 32'hA0, 0, -1, 0, bresp, bid, lat_ok, timeout);
        do_read(8'h03, 32'hA0, 0, 0, lat_ok, stable_ok, timeout);
        n_checks++;
        if (timeout || rdata_buf[0] !== expv) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h expected %h", rdata_buf[0], expv);
        end
    endtask

    task automatic test_error;
        logic [1:0] bresp;
        logic [7:0] bid;
        bit lat_ok, stable_ok, timeout;
        for (int b = 0; b < 4; b++) begin
            wdata_buf[b] = rand_word();
            wstrb_buf[b] = '1;
        end
        do_write(8'h44, 32'h100, 3, 1, 0, bresp, bid, lat_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || bresp !== 2'b10 || bid !== 8'h44) begin
            n_fail++;
            $display("FAIL early_wlast_bresp: got to=%0d lat=%0d bresp=%b bid=%h expected 0 1 10 44",
                     timeout, lat_ok, bresp, bid);
        end
        do_read(8'h45, 32'h100, 3, 0, lat_ok, stable_ok, timeout);
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (rdata_buf[b] !== model_mem[(8 + b) % DEPTH]) begin
                n_fail++;
                $display("FAIL early_wlast_data%0d: got %h expected %h",
                         b, rdata_buf[b], model_mem[(8 + b) % DEPTH]);
            end
        end
    endtask

    task automatic test_wrap_collision;
        logic [1:0] bresp;
        logic [7:0] bid;
        logic [DW-1:0] old_val;
        bit lat_ok, stable_ok, timeout;
        wdata_buf[0] = rand_word();
        wstrb_buf[0] = '1;
        do_write(8'h50, 32'h0, 0, -1, 0, bresp, bid, lat_ok, timeout);
        old_val = model_mem[0];
        for (int b = 0; b < 4; b++) begin
            wdata_buf[b] = rand_word();
            wstrb_buf[b] = '1;
        end
        axi_awid = 8'h51;
        axi_awaddr = 32'(14 * 32);
        axi_awlen = 8'd3;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            axi_wdata = wdata_buf[b];
            axi_wstrb = '1;
            axi_wlast = (b == 3);
            axi_wvalid = 1'b1;
            // Beat 2 lands on word 0; launch the read of word 0 on the same edge.
            if (b == 2) begin
                axi_arid = 8'h52;
                axi_araddr = 32'h0;
                axi_arlen = 8'd0;
                axi_arvalid = 1'b1;
            end
            if (b == 3) begin
                n_checks++;
                if (axi_rvalid !== 1'b1 || axi_rdata !== old_val) begin
                    n_fail++;
                    $display("FAIL collision_read_first: got v=%b %h expected 1 %h",
                             axi_rvalid, axi_rdata, old_val);
                end
                axi_rready = 1'b1;
            end
            tick();
            axi_arvalid = 1'b0;
        end
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
        axi_rready = 1'b0;
        n_checks++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== 2'b00 || axi_bid !== 8'h51) begin
            n_fail++;
            $display("FAIL wrap_bresp: got v=%b resp=%b bid=%h expected 1 00 51",
                     axi_bvalid, axi_bresp, axi_bid);
        end
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        model_write(14, 3);
        do_read(8'h53, 32'(14 * 32), 3, 0, lat_ok, stable_ok, timeout);
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (timeout || rdata_buf[b] !== wdata_buf[b]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h expected %h",
                         (14 + b) % DEPTH, rdata_buf[b], wdata_buf[b]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0] bresp;
        logic [7:0] bid, id;
        logic [31:0] addr;
        int len;
        bit lat_ok, stable_ok, timeout;
        for (int it = 0; it < 8; it++) begin
            len = (it == 0) ? 0 : $urandom_range(0, 9);
            id = 8'($urandom);
            addr = $urandom;
            for (int b = 0; b <= len; b++) begin
                wdata_buf[b] = rand_word();
                wstrb_buf[b] = $urandom_range(0, 1) ? '1 : SW'($urandom);
            end
            do_write(id, addr, len, -1, 1, bresp, bid, lat_ok, timeout);
            n_checks++;
            if (timeout || !lat_ok || bresp !== 2'b00 || bid !== id) begin
                n_fail++;
                $display("FAIL rand%0d_write: got to=%0d lat=%0d bresp=%b bid=%h expected 0 1 00 %h",
                         it, timeout, lat_ok, bresp, bid, id);
            end
            do_read(~id, addr, len, 1, lat_ok, stable_ok, timeout);
            n_checks++;
            if (timeout || !lat_ok || !stable_ok) begin
                n_fail++;
                $display("FAIL rand%0d_read_protocol: got to=%0d lat=%0d stable=%0d expected 0 1 1",
                         it, timeout, lat_ok, stable_ok);
            end
            for (int b = 0; b <= len; b++) begin
                n_checks++;
                if (rdata_buf[b] !== model_mem[(word_of(addr) + b) % DEPTH]
                    || rlast_buf[b] !== (b == len) || rid_buf[b] !== ~id) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h last=%b expected %h last=%0d",
                             it, b, rdata_buf[b], rlast_buf[b],
                             model_mem[(word_of(addr) + b) % DEPTH], b == len);
                end
            end
        end
    endtask

    task automatic test_max_len;
        logic [1:0] bresp;
        logic [7:0] bid;
        bit lat_ok, stable_ok, timeout;
        int errs;
        for (int b = 0; b < 256; b++) begin
            wdata_buf[b] = rand_word();
            wstrb_buf[b] = '1;
        end
        do_write(8'h77, 32'h60, 255, -1, 0, bresp, bid, lat_ok, timeout);
        n_checks++;
        if (timeout || !lat_ok || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL max_len_write: got to=%0d lat=%0d bresp=%b expected 0 1 00",
                     timeout, lat_ok, bresp);
        end
        do_read(8'h78, 32'h60, 255, 0, lat_ok, stable_ok, timeout);
        errs = 0;
        for (int b = 0; b < 256; b++) begin
            if (rdata_buf[b] !== model_mem[(3 + b) % DEPTH] || rlast_buf[b] !== (b == 255))
                errs++;
        end
        n_checks++;
        if (timeout || !lat_ok || errs != 0) begin
            n_fail++;
            $display("FAIL max_len_read: got to=%0d lat=%0d bad_beats=%0d expected 0 1 0",
                     timeout, lat_ok, errs);
        end
    endtask

    task automatic test_reset_mid_burst;
        bit lat_ok, stable_ok, timeout;
        axi_arid = 8'h66;
        axi_araddr = 32'h0;
        axi_arlen = 8'd7;
        axi_arvalid = 1'b1;
        tick();
        axi_arvalid = 1'b0;
        axi_rready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({axi_rvalid, axi_arready, axi_awready, axi_wready, axi_bvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got %b expected 00000",
                     {axi_rvalid, axi_arready, axi_awready, axi_wready, axi_bvalid});
        end
        axi_rready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (axi_arready !== 1'b0 || axi_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_arready: got ar=%b rv=%b expected 0 0",
                     axi_arready, axi_rvalid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_live_arready: got %b expected 1", axi_arready);
        end
        do_read(8'h67, 32'h0, 3, 0, lat_ok, stable_ok, timeout);
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (timeout || rdata_buf[b] !== model_mem[b]) begin
                n_fail++;
                $display("FAIL reset_ram_kept%0d: got %h expected %h", b, rdata_buf[b], model_mem[b]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_strobe();
        test_error();
        test_wrap_collision();
        test_random();
        test_max_len();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
